// File: rtl/framebuffer_writer.sv
// Purpose    : fills the VGA framebuffer with screen-clipped solid rectangles, writing one pixel per cycle in row-major order.
// Latency    : the first write is 2 cycles after accept. N pixels end with done at cycle N+2 and the block is ready again at N+3.
// Backpressure: cmd_ready is high only in IDLE. A cmd_valid seen while busy is ignored, so the issuer holds it until accepted.
//
// Ports:
//   clock, reset             single clock; asynchronous active-low reset
//   cmd_valid / cmd_ready    command handshake; cmd_x0/y0/w/h/color are latched on accept
//   busy, done               busy outside IDLE; done pulses one cycle per completed command
//   mem_we/mem_addr/mem_wdata framebuffer write port; addr = y*screenX + x, data = {b,g,r}
module framebuffer_writer #(
    parameter int screenX = 50,
    parameter int screenY = 50,
    parameter int ADDR_W  = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [9:0]        cmd_x0,
    input  logic [9:0]        cmd_y0,
    input  logic [9:0]        cmd_w,
    input  logic [9:0]        cmd_h,
    input  logic [2:0]        cmd_color,
    output logic              busy,
    output logic              done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [2:0]        mem_wdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_FILL  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Screen limits in 11 bits so that x0+w and y0+h cannot wrap.
    localparam logic [10:0]       SX11 = 11'(screenX);
    localparam logic [10:0]       SY11 = 11'(screenY);
    localparam logic [ADDR_W-1:0] SXA  = ADDR_W'(screenX);

    logic [1:0]        state_q, state_d;
    logic [9:0]        x0_q, x0_d;
    logic [9:0]        y0_q, y0_d;
    logic [9:0]        w_q, w_d;
    logic [9:0]        h_q, h_d;
    logic [2:0]        color_q, color_d;
    logic [10:0]       x_end_q, x_end_d;
    logic [10:0]       y_end_q, y_end_d;
    logic [10:0]       x_q, x_d;
    logic [10:0]       y_q, y_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        wdata_q, wdata_d;

    // Clipping and start address from the latched command. These are used only in SETUP.
    logic [10:0]       x0_ext, y0_ext, x_sum, y_sum, x_end_c, y_end_c;
    logic              empty_c;
    logic [ADDR_W-1:0] x0_addr, row_base_c;
    logic              x_last, y_last;

    assign x0_ext  = {1'b0, x0_q};
    assign y0_ext  = {1'b0, y0_q};
    assign x_sum   = x0_ext + {1'b0, w_q};
    assign y_sum   = y0_ext + {1'b0, h_q};
    assign x_end_c = (x_sum > SX11) ? SX11 : x_sum;
    assign y_end_c = (y_sum > SY11) ? SY11 : y_sum;
    assign empty_c = (w_q == 10'd0) || (h_q == 10'd0) || (x0_ext >= SX11) || (y0_ext >= SY11);
    assign x0_addr = ADDR_W'(x0_q);
    // Truncating the product is safe: it is used only when y0 < screenY.
    assign row_base_c = ADDR_W'(y0_q) * SXA;

    assign x_last = (x_q + 11'd1) == x_end_q;
    assign y_last = (y_q + 11'd1) == y_end_q;

    always_comb begin
        state_d    = state_q;
        x0_d       = x0_q;
        y0_d       = y0_q;
        w_d        = w_q;
        h_d        = h_q;
        color_d    = color_q;
        x_end_d    = x_end_q;
        y_end_d    = y_end_q;
        x_d        = x_q;
        y_d        = y_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    x0_d    = cmd_x0;
                    y0_d    = cmd_y0;
                    w_d     = cmd_w;
                    h_d     = cmd_h;
                    color_d = cmd_color;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                x_end_d    = x_end_c;
                y_end_d    = y_end_c;
                x_d        = x0_ext;
                y_d        = y0_ext;
                row_base_d = row_base_c;
                if (empty_c) begin
                    state_d = S_DONE;
                end else begin
                    // Load the write port at the same edge that enters FILL.
                    // mem_addr and mem_wdata stay unchanged until the first write.
                    addr_d  = row_base_c + x0_addr;
                    wdata_d = color_q;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (x_last) begin
                    if (y_last) begin
                        state_d = S_DONE;
                    end else begin
                        // Next row: advance the base by one stride. This avoids a per-pixel multiply.
                        x_d        = x0_ext;
                        y_d        = y_q + 11'd1;
                        row_base_d = row_base_q + SXA;
                        addr_d     = row_base_q + SXA + x0_addr;
                    end
                end else begin
                    x_d    = x_q + 11'd1;
                    addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            x0_q       <= '0;
            y0_q       <= '0;
            w_q        <= '0;
            h_q        <= '0;
            color_q    <= '0;
            x_end_q    <= '0;
            y_end_q    <= '0;
            x_q        <= '0;
            y_q        <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            w_q        <= w_d;
            h_q        <= h_d;
            color_q    <= color_d;
            x_end_q    <= x_end_d;
            y_end_q    <= y_end_d;
            x_q        <= x_d;
            y_q        <= y_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    // Control outputs decode the state register directly.
    // Reset therefore drops mem_we and busy immediately, even in the middle of a fill.
    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign mem_we    = (state_q == S_FILL);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule
